// File: rtl/sram_ctrl.sv
// sram_ctrl: memory-side controller between the CPU request interface and an
// asynchronous external SRAM. One request is in flight at a time. Read and write
// strobe widths are set by READ_WAIT / WRITE_WAIT. Each write is followed by one
// hold cycle, so address and data stay stable after WE rises.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   mem_addr, mem_data_in         CPU request address / write data
//   mem_r_en, mem_w_en            CPU read / write request (read wins if both)
//   mem_data_out                  last completed read data
//   mem_rdy                       request can be accepted this cycle
//   mem_cplt                      one-cycle completion pulse
//   sram_addr, sram_dq_out        registered SRAM address / write data
//   sram_dq_oe                    DQ tristate enable for the top level
//   sram_dq_in                    SRAM read data
//   sram_ce_n, sram_oe_n, sram_we_n  active-low SRAM strobes
module sram_ctrl #(
    parameter int unsigned MEM_ADDR_WIDTH = 18,
    parameter int unsigned DATA_WIDTH     = 16,
    parameter int unsigned READ_WAIT      = 2,
    parameter int unsigned WRITE_WAIT     = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [MEM_ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0]     mem_data_in,
    input  logic                      mem_r_en,
    input  logic                      mem_w_en,
    output logic [DATA_WIDTH-1:0]     mem_data_out,
    output logic                      mem_rdy,
    output logic                      mem_cplt,
    output logic [MEM_ADDR_WIDTH-1:0] sram_addr,
    output logic [DATA_WIDTH-1:0]     sram_dq_out,
    output logic                      sram_dq_oe,
    input  logic [DATA_WIDTH-1:0]     sram_dq_in,
    output logic                      sram_ce_n,
    output logic                      sram_oe_n,
    output logic                      sram_we_n
);

    localparam int unsigned MAX_WAIT = (READ_WAIT > WRITE_WAIT) ? READ_WAIT : WRITE_WAIT;
    localparam int unsigned CNT_W    = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] READ_LOAD  = CNT_W'(READ_WAIT - 1);
    localparam logic [CNT_W-1:0] WRITE_LOAD = CNT_W'(WRITE_WAIT - 1);

    typedef enum logic [2:0] {StIdle, StRead, StWrite, StHold, StCplt} state_e;

    state_e                    state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [MEM_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0]     dq_out_q, dq_out_d;
    logic [DATA_WIDTH-1:0]     data_out_q, data_out_d;
    logic                      dq_oe_q, dq_oe_d;
    logic                      ce_n_q, ce_n_d;
    logic                      oe_n_q, oe_n_d;
    logic                      we_n_q, we_n_d;
    logic                      cplt_q, cplt_d;

    // Every output below is a register; the strobe values for a state are loaded
    // on the edge that enters that state.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        dq_out_d   = dq_out_q;
        data_out_d = data_out_q;
        dq_oe_d    = dq_oe_q;
        ce_n_d     = ce_n_q;
        oe_n_d     = oe_n_q;
        we_n_d     = we_n_q;
        cplt_d     = 1'b0;

        case (state_q)
            StIdle: begin
                if (mem_r_en || mem_w_en) begin
                    addr_d   = mem_addr;
                    dq_out_d = mem_data_in;
                    ce_n_d   = 1'b0;
                    if (mem_r_en) begin
                        // Read has priority; a simultaneous write is dropped.
                        state_d = StRead;
                        cnt_d   = READ_LOAD;
                        oe_n_d  = 1'b0;
                    end else begin
                        state_d = StWrite;
                        cnt_d   = WRITE_LOAD;
                        we_n_d  = 1'b0;
                        dq_oe_d = 1'b1;
                    end
                end
            end
            StRead: begin
                if (cnt_q == '0) begin
                    data_out_d = sram_dq_in;
                    ce_n_d     = 1'b1;
                    oe_n_d     = 1'b1;
                    cplt_d     = 1'b1;
                    state_d    = StCplt;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            StWrite: begin
                if (cnt_q == '0) begin
                    // WE rises first; CE and DQ drive stay on for the hold cycle.
                    we_n_d  = 1'b1;
                    state_d = StHold;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            StHold: begin
                ce_n_d  = 1'b1;
                dq_oe_d = 1'b0;
                cplt_d  = 1'b1;
                state_d = StCplt;
            end
            StCplt: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
                ce_n_d  = 1'b1;
                oe_n_d  = 1'b1;
                we_n_d  = 1'b1;
                dq_oe_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            addr_q     <= '0;
            dq_out_q   <= '0;
            data_out_q <= '0;
            dq_oe_q    <= 1'b0;
            ce_n_q     <= 1'b1;
            oe_n_q     <= 1'b1;
            we_n_q     <= 1'b1;
            cplt_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            dq_out_q   <= dq_out_d;
            data_out_q <= data_out_d;
            dq_oe_q    <= dq_oe_d;
            ce_n_q     <= ce_n_d;
            oe_n_q     <= oe_n_d;
            we_n_q     <= we_n_d;
            cplt_q     <= cplt_d;
        end
    end

    assign mem_rdy      = (state_q == StIdle) && !rst;
    assign mem_cplt     = cplt_q;
    assign mem_data_out = data_out_q;
    assign sram_addr    = addr_q;
    assign sram_dq_out  = dq_out_q;
    assign sram_dq_oe   = dq_oe_q;
    assign sram_ce_n    = ce_n_q;
    assign sram_oe_n    = oe_n_q;
    assign sram_we_n    = we_n_q;

endmodule
